// File: rtl/game_pkg.sv
// game_pkg: shared encodings and coordinate widths for the game datapath.
package game_pkg;

    // Screen coordinate widths in pixels.
    localparam int unsigned X_W = 11;
    localparam int unsigned Y_W = 10;

    // Engine state encoding; the numeric values are visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    // One-hot sprite direction codes shared with the movement logic.
    typedef enum logic [3:0] {
        DIR_RIGHT = 4'b0001,
        DIR_UP    = 4'b0010,
        DIR_DOWN  = 4'b0100,
        DIR_LEFT  = 4'b1000
    } dir_e;

    // Sprite position on screen.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/game_state_engine_if.sv
// game_state_engine_if: sprite positions in, game status out.
// The pause input exists only when GAME_STATE_PAUSE_EN is defined.
interface game_state_engine_if #(
    parameter int unsigned NUM_GHOSTS = 4
) ();
    import game_pkg::*;

    logic                      start;
    logic [X_W-1:0]            pacman_x;
    logic [Y_W-1:0]            pacman_y;
    logic [NUM_GHOSTS*X_W-1:0] ghost_x;
    logic [NUM_GHOSTS*Y_W-1:0] ghost_y;
`ifdef GAME_STATE_PAUSE_EN
    logic                      pause;
`endif

    logic                      move_tick;
    logic                      respawn;
    logic [1:0]                state;
    logic [2:0]                lives;
    logic [NUM_GHOSTS-1:0]     hit_mask;
    logic                      pacman_is_dead;
    logic                      game_over;

`ifdef GAME_STATE_PAUSE_EN
    modport master (
        output start, pacman_x, pacman_y, ghost_x, ghost_y, pause,
        input  move_tick, respawn, state, lives, hit_mask, pacman_is_dead, game_over
    );
    modport slave (
        input  start, pacman_x, pacman_y, ghost_x, ghost_y, pause,
        output move_tick, respawn, state, lives, hit_mask, pacman_is_dead, game_over
    );
`else
    modport master (
        output start, pacman_x, pacman_y, ghost_x, ghost_y,
        input  move_tick, respawn, state, lives, hit_mask, pacman_is_dead, game_over
    );
    modport slave (
        input  start, pacman_x, pacman_y, ghost_x, ghost_y,
        output move_tick, respawn, state, lives, hit_mask, pacman_is_dead, game_over
    );
`endif

endinterface

// File: rtl/hit_detect.sv
// hit_detect: per-axis proximity window between one ghost and pacman.
// Differences are taken one bit wider than the coordinates so they never wrap.
module hit_detect
    import game_pkg::*;
#(
    parameter int unsigned HIT_RADIUS = 16
) (
    input  coord_t ghost,
    input  coord_t pacman,
    output logic   hit_c
);

    localparam int unsigned DX_W = X_W + 1;
    localparam int unsigned DY_W = Y_W + 1;

    logic [DX_W-1:0] dx_c;
    logic [DY_W-1:0] dy_c;

    // Unsigned absolute distance on each axis, then the strict window test.
    always_comb begin
        if (ghost.x >= pacman.x) begin
            dx_c = DX_W'(ghost.x) - DX_W'(pacman.x);
        end else begin
            dx_c = DX_W'(pacman.x) - DX_W'(ghost.x);
        end
        if (ghost.y >= pacman.y) begin
            dy_c = DY_W'(ghost.y) - DY_W'(pacman.y);
        end else begin
            dy_c = DY_W'(pacman.y) - DY_W'(ghost.y);
        end
        hit_c = (32'(dx_c) < HIT_RADIUS) && (32'(dy_c) < HIT_RADIUS);
    end

endmodule

// File: rtl/game_state_engine.sv
// game_state_engine: game flow (idle/play/dying/over), lives, movement tick
// and ghost collision handling.
// Optional build macro GAME_STATE_PAUSE_EN adds a pause input that freezes
// play (tick and collisions); without it the engine behaves as never paused.
module game_state_engine
    import game_pkg::*;
#(
    parameter int unsigned NUM_GHOSTS  = 4,
    parameter int unsigned TICK_DIV    = 2,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned DEATH_TICKS = 64,
    parameter int unsigned HIT_RADIUS  = 16
) (
    input  logic                clk,
    input  logic                rst,
    game_state_engine_if.slave  bus
);

    localparam int unsigned       CNT_W      = 8;
    localparam int unsigned       LIVES_W    = 3;
    localparam logic [CNT_W-1:0]  TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  DEATH_LOAD = CNT_W'(DEATH_TICKS - 1);

    game_state_e             state_q,          state_d;
    logic [LIVES_W-1:0]      lives_q,          lives_d;
    logic [NUM_GHOSTS-1:0]   hit_mask_q,       hit_mask_d;
    logic [CNT_W-1:0]        tick_q,           tick_d;
    logic [CNT_W-1:0]        death_q,          death_d;
    logic                    move_tick_q,      move_tick_d;
    logic                    respawn_q,        respawn_d;
    logic                    pacman_is_dead_q, pacman_is_dead_d;
    logic                    game_over_q,      game_over_d;

    logic [NUM_GHOSTS-1:0]   hit_vec_c;
    logic                    any_hit_c;
    logic                    pause_c;
    coord_t                  pacman_c;

`ifdef GAME_STATE_PAUSE_EN
    assign pause_c = bus.pause;
`else
    assign pause_c = 1'b0;
`endif

    assign pacman_c = {bus.pacman_x, bus.pacman_y};

    // One proximity checker per ghost channel.
    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
        coord_t ghost_c;
        assign ghost_c = {bus.ghost_x[g*X_W +: X_W], bus.ghost_y[g*Y_W +: Y_W]};

        hit_detect #(
            .HIT_RADIUS (HIT_RADIUS)
        ) u_hit_detect (
            .ghost  (ghost_c),
            .pacman (pacman_c),
            .hit_c  (hit_vec_c[g])
        );
    end

    assign any_hit_c = |hit_vec_c;

    // Next-state and next-output logic for the game flow.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        hit_mask_d  = hit_mask_q;
        tick_d      = tick_q;
        death_d     = death_q;
        move_tick_d = 1'b0;
        respawn_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_d    = ST_PLAY;
                    lives_d    = LIVES_W'(LIVES);
                    hit_mask_d = '0;
                    tick_d     = '0;
                    death_d    = '0;
                    respawn_d  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (!pause_c) begin
                    if (any_hit_c) begin
                        // A death outranks a movement step on the same cycle.
                        state_d    = ST_DYING;
                        lives_d    = lives_q - LIVES_W'(1);
                        hit_mask_d = hit_vec_c;
                        death_d    = DEATH_LOAD;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d      = '0;
                        move_tick_d = 1'b1;
                    end else begin
                        tick_d = tick_q + CNT_W'(1);
                    end
                end
            end
            ST_DYING: begin
                if (death_q == '0) begin
                    if (lives_q == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d    = ST_PLAY;
                        respawn_d  = 1'b1;
                        tick_d     = '0;
                        hit_mask_d = '0;
                    end
                end else begin
                    death_d = death_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pacman_is_dead_d = (state_d == ST_DYING);
        game_over_d      = (state_d == ST_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            lives_q          <= '0;
            hit_mask_q       <= '0;
            tick_q           <= '0;
            death_q          <= '0;
            move_tick_q      <= 1'b0;
            respawn_q        <= 1'b0;
            pacman_is_dead_q <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            lives_q          <= lives_d;
            hit_mask_q       <= hit_mask_d;
            tick_q           <= tick_d;
            death_q          <= death_d;
            move_tick_q      <= move_tick_d;
            respawn_q        <= respawn_d;
            pacman_is_dead_q <= pacman_is_dead_d;
            game_over_q      <= game_over_d;
        end
    end

    assign bus.state          = state_q;
    assign bus.lives          = lives_q;
    assign bus.hit_mask       = hit_mask_q;
    assign bus.move_tick      = move_tick_q;
    assign bus.respawn        = respawn_q;
    assign bus.pacman_is_dead = pacman_is_dead_q;
    assign bus.game_over      = game_over_q;

endmodule

// File: tb/tb_game_state_engine.sv
// tb_game_state_engine: directed and random stimulus against a behavioural
// model of the game rules; expected status per clock is queued and checked
// by an independent monitor.
module tb_game_state_engine;
    import game_pkg::*;

    localparam int unsigned NG = 4;
    localparam int unsigned TD = 2;
    localparam int unsigned LV = 3;
    localparam int unsigned DT = 64;
    localparam int unsigned HR = 16;

    typedef struct packed {
        logic [1:0]    st;
        logic [2:0]    lv;
        logic [NG-1:0] hm;
        logic          mt;
        logic          rs;
        logic          dead;
        logic          over;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_state_engine_if #(.NUM_GHOSTS(NG)) bus ();

    game_state_engine #(
        .NUM_GHOSTS  (NG),
        .TICK_DIV    (TD),
        .LIVES       (LV),
        .DEATH_TICKS (DT),
        .HIT_RADIUS  (HR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    // Current screen positions driven by the stimulus.
    int px, py;
    int gx[NG];
    int gy[NG];

    // Behavioural model: game mode as a number, lives, unpaused play cycles
    // since the last respawn, cycles spent dying, and the latched victims.
    int            m_mode  = 0;
    int            m_lives = 0;
    int            m_moves = 0;
    int            m_dying = 0;
    logic [NG-1:0] m_mask  = '0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc_n, act, req);
        end
    endtask

    function automatic logic [NG-1:0] overlap();
        logic [NG-1:0] m = '0;
        for (int i = 0; i < int'(NG); i++) begin
            int dx = gx[i] - px;
            int dy = gy[i] - py;
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            m[i] = (dx < int'(HR)) && (dy < int'(HR));
        end
        return m;
    endfunction

    task automatic model_step(input logic r, input logic s, input logic p);
        exp_t          e;
        logic          mt = 1'b0;
        logic          rs = 1'b0;
        logic [NG-1:0] h;
        if (r) begin
            m_mode = 0; m_lives = 0; m_mask = '0; m_moves = 0; m_dying = 0;
        end else if (m_mode == 0 || m_mode == 3) begin
            if (s) begin
                m_mode = 1; m_lives = int'(LV); m_mask = '0; m_moves = 0; rs = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (!p) begin
                h = overlap();
                if (h != '0) begin
                    m_mode = 2; m_lives = m_lives - 1; m_mask = h; m_dying = 0;
                end else begin
                    m_moves = m_moves + 1;
                    mt = ((m_moves % int'(TD)) == 0);
                end
            end
        end else begin
            m_dying = m_dying + 1;
            if (m_dying == int'(DT)) begin
                if (m_lives == 0) begin
                    m_mode = 3;
                end else begin
                    m_mode = 1; rs = 1'b1; m_moves = 0; m_mask = '0;
                end
            end
        end
        e.st   = 2'(m_mode);
        e.lv   = 3'(m_lives);
        e.hm   = m_mask;
        e.mt   = mt;
        e.rs   = rs;
        e.dead = (m_mode == 2);
        e.over = (m_mode == 3);
        exp_q.push_back(e);
    endtask

    // Apply one clock of inputs, then queue what the rules say must follow.
    task automatic cycle(input logic r, input logic s, input logic p);
        logic p_eff;
`ifdef GAME_STATE_PAUSE_EN
        p_eff = p;
        bus.pause = p;
`else
        p_eff = 1'b0;
`endif
        rst       = r;
        bus.start = s;
        bus.pacman_x = X_W'(px);
        bus.pacman_y = Y_W'(py);
        for (int i = 0; i < int'(NG); i++) begin
            bus.ghost_x[i*X_W +: X_W] = X_W'(gx[i]);
            bus.ghost_y[i*Y_W +: Y_W] = Y_W'(gy[i]);
        end
        @(posedge clk);
        model_step(r, s, p_eff);
        #1;
    endtask

    task automatic ghosts_far();
        for (int i = 0; i < int'(NG); i++) begin
            gx[i] = px + 200 + 30 * i;
            gy[i] = py;
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Monitor: every clock the engine presents its status; compare it.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cyc_n++;
                chk("state",          int'(bus.state),          int'(e.st));
                chk("lives",          int'(bus.lives),          int'(e.lv));
                chk("hit_mask",       int'(bus.hit_mask),       int'(e.hm));
                chk("move_tick",      int'(bus.move_tick),      int'(e.mt));
                chk("respawn",        int'(bus.respawn),        int'(e.rs));
                chk("pacman_is_dead", int'(bus.pacman_is_dead), int'(e.dead));
                chk("game_over",      int'(bus.game_over),      int'(e.over));
            end
        end
    end

    initial begin : stim
        px = 500;
        py = 300;
        ghosts_far();

        // Reset, then a one-cycle start and a stretch of plain play.
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (9) cycle(1'b0, 1'b0, 1'b0);

        // Ghost 2 just outside, then just inside, the window.
        gx[2] = px + 16; gy[2] = py;
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        gx[2] = px + 15;
        cycle(1'b0, 1'b0, 1'b0);
        ghosts_far();
        repeat (DT + 4) cycle(1'b0, 1'b0, 1'b0);

        // Collision landing on a tick-wrap edge.
        for (int k = 0; k < int'(TD) && (((m_moves + 1) % int'(TD)) != 0); k++)
            cycle(1'b0, 1'b0, 1'b0);
        gx[0] = px - 3; gy[0] = py + 15;
        cycle(1'b0, 1'b0, 1'b0);
        ghosts_far();
        repeat (DT + 3) cycle(1'b0, 1'b0, 1'b0);

        // Third death with two ghosts; start pulses while dying are ignored.
        gx[1] = px + 10; gy[1] = py - 10;
        gx[3] = px;      gy[3] = py;
        cycle(1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0);
        repeat (DT) cycle(1'b0, 1'b0, 1'b0);

        // In OVER the overlapping ghosts must be ignored; then restart.
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        ghosts_far();
        cycle(1'b0, 1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0);

        // Reset mid-dying, with start on the same edge.
        gx[3] = px; gy[3] = py;
        cycle(1'b0, 1'b0, 1'b0);
        ghosts_far();
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // Reset beats a collision; the collision is then ignored in IDLE.
        cycle(1'b0, 1'b1, 1'b0);
        gx[0] = px; gy[0] = py;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        ghosts_far();

`ifdef GAME_STATE_PAUSE_EN
        // Paused play freezes the tick and masks an overlapping ghost.
        cycle(1'b0, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        gx[1] = px + 5; gy[1] = py - 5;
        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        ghosts_far();
        cycle(1'b1, 1'b0, 1'b0);
`endif

        // Random play around and away from pacman, including screen edges.
        for (int k = 0; k < 1500; k++) begin
            if ((k % 8) == 0) begin
                px = int'($urandom_range(0, 2047));
                py = int'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) == 0) px = int'($urandom_range(0, 12));
                for (int i = 0; i < int'(NG); i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        gx[i] = clampi(px + int'($urandom_range(0, 40)) - 20, 0, 2047);
                        gy[i] = clampi(py + int'($urandom_range(0, 40)) - 20, 0, 1023);
                    end else begin
                        gx[i] = int'($urandom_range(0, 2047));
                        gy[i] = int'($urandom_range(0, 1023));
                    end
                end
            end
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
